// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// Writer-side front end for the PLC program memory. Parses a framed load
// command from a byte stream (valid/ready), packs every three data bytes
// into one DW-bit instruction word and writes it to consecutive addresses.
// A trailing XOR checksum decides between DONE and ERR. BUSY covers the
// whole frame so the logic cores hold off instruction fetch meanwhile.
//
// Frame: SYNC, CNT_H, CNT_L, ADR_H, ADR_L, N x (b0 b1 b2), CSUM
//   N     = {CNT_H,CNT_L}, legal range 1 .. 2**AW
//   start = {ADR_H,ADR_L}[AW-1:0]
//   word  = {b0,b1,b2}[DW-1:0]         (DW must lie in 17..24)
//   CSUM  = XOR of CNT_H .. last data byte (SYNC excluded)
//
// Every output is a flop, so an asserted RST clears all of them at once
// and a mid-frame reset drops any partially assembled word.

module prog_mem_loader #(
    parameter int         DW   = 18,
    parameter int         AW   = 12,
    parameter logic [7:0] SYNC = 8'hA5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          RX_READY,
    output logic [AW-1:0] A,
    output logic          WE,
    output logic [DW-1:0] DI,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW:0]   WCNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    // Largest legal word count: the whole address space, written once.
    localparam logic [16:0] MAX_WORDS = 17'(2 ** AW);

    // Registered state and datapath.
    state_t      state_q;
    logic [1:0]  idx_q;      // byte index inside the header or inside a word
    logic [15:0] cnt_q;      // N as received
    logic [7:0]  adr_h_q;    // ADR_H, held until ADR_L arrives
    logic [7:0]  b0_q;       // first byte of the word being assembled
    logic [7:0]  b1_q;       // second byte of the word being assembled
    logic [7:0]  csum_q;     // running XOR from CNT_H onwards

    // Next-state values produced by the combinational process.
    state_t        state_d;
    logic [1:0]    idx_d;
    logic [15:0]   cnt_d;
    logic [7:0]    adr_h_d;
    logic [7:0]    b0_d;
    logic [7:0]    b1_d;
    logic [7:0]    csum_d;
    logic          rx_ready_d;
    logic [AW-1:0] a_d;
    logic          we_d;
    logic [DW-1:0] di_d;
    logic          busy_d;
    logic          done_d;
    logic          err_d;
    logic [AW:0]   wcnt_d;

    // Helper terms.
    logic        fire;        // a byte is transferred at this edge
    logic [15:0] adr_full;    // {ADR_H, ADR_L} while ADR_L is on the bus
    logic [23:0] word_full;   // {b0, b1, b2} while b2 is on the bus
    logic        count_bad;   // N outside 1 .. 2**AW
    logic        last_word;   // the word being written completes the frame
    logic        unused_bits; // sink for address/word bits above AW/DW

    assign fire        = RX_VALID && RX_READY;
    assign adr_full    = {adr_h_q, RX_DATA};
    assign word_full   = {b0_q, b1_q, RX_DATA};
    assign count_bad   = (cnt_q == 16'd0) || ({1'b0, cnt_q} > MAX_WORDS);
    assign last_word   = (32'(WCNT) + 32'd1) == 32'(cnt_q);
    assign unused_bits = ^{adr_full, word_full};

    // State register and all output flops; asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 16'd0;
            adr_h_q  <= 8'd0;
            b0_q     <= 8'd0;
            b1_q     <= 8'd0;
            csum_q   <= 8'd0;
            RX_READY <= 1'b0;
            A        <= '0;
            WE       <= 1'b0;
            DI       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            WCNT     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            adr_h_q  <= adr_h_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            csum_q   <= csum_d;
            RX_READY <= rx_ready_d;
            A        <= a_d;
            WE       <= we_d;
            DI       <= di_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ERR      <= err_d;
            WCNT     <= wcnt_d;
        end
    end

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        // NOTE: everything holds by default (WE defaults low), so no branch
        // can leave a signal unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        adr_h_d = adr_h_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        csum_d  = csum_q;
        a_d     = A;
        we_d    = 1'b0;
        di_d    = DI;
        busy_d  = BUSY;
        done_d  = DONE;
        err_d   = ERR;
        wcnt_d  = WCNT;

        unique case (state_q)
            // Discard everything except SYNC; SYNC opens a new frame.
            S_IDLE: begin
                if (fire && (RX_DATA == SYNC)) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    csum_d  = 8'd0;
                    busy_d  = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_HDR;
                end
            end

            // CNT_H, CNT_L, ADR_H, ADR_L; the count is validated on ADR_L.
            S_HDR: begin
                if (fire) begin
                    csum_d = csum_q ^ RX_DATA;
                    idx_d  = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: cnt_d[15:8] = RX_DATA;
                        2'd1: cnt_d[7:0]  = RX_DATA;
                        2'd2: adr_h_d     = RX_DATA;
                        default: begin
                            idx_d = 2'd0;
                            if (count_bad) begin
                                err_d   = 1'b1;
                                busy_d  = 1'b0;
                                state_d = S_IDLE;
                            end else begin
                                a_d     = adr_full[AW-1:0];
                                state_d = S_DATA;
                            end
                        end
                    endcase
                end
            end

            // Collect b0, b1, b2; the third byte launches the write.
            S_DATA: begin
                if (fire) begin
                    csum_d = csum_q ^ RX_DATA;
                    idx_d  = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: b0_d = RX_DATA;
                        2'd1: b1_d = RX_DATA;
                        default: begin
                            idx_d   = 2'd0;
                            we_d    = 1'b1;
                            di_d    = word_full[DW-1:0];
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end

            // Single write cycle: advance the address (wrapping) and count.
            S_WRITE: begin
                a_d     = A + AW'(1);
                wcnt_d  = WCNT + (AW + 1)'(1);
                state_d = last_word ? S_CSUM : S_DATA;
            end

            // Trailing checksum byte closes the frame either way.
            S_CSUM: begin
                if (fire) begin
                    if (RX_DATA == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The byte interface pauses only while a word is being written.
        rx_ready_d = (state_d != S_WRITE);
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader
// Randomised frames are fed through a valid/ready driver with random gaps.
// A frame-level reference model predicts the memory writes and the final
// DONE/ERR/WCNT; monitors compare against the DUT whenever WE pulses or
// BUSY falls.

module tb_prog_mem_loader;

    localparam int DW = 18;
    localparam int AW = 12;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [23:0] word_q_t[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [AW:0] wcnt;
    } res_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [7:0]    RX_DATA;
    logic          RX_VALID;
    logic          RX_READY;
    logic [AW-1:0] A;
    logic          WE;
    logic [DW-1:0] DI;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [AW:0]   WCNT;

    wr_t  exp_wr[$];
    res_t exp_res[$];

    int   checks    = 0;
    int   errors    = 0;
    int   max_gap   = 0;
    int   bad_ready = 0;
    logic rst_last  = 1'b1;
    logic busy_prev = 1'b0;

    prog_mem_loader #(
        .DW   (DW),
        .AW   (AW),
        .SYNC (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .A        (A),
        .WE       (WE),
        .DI       (DI),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .WCNT     (WCNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: decode the bytes, predict writes and result.
    task automatic model_frame(input byte_q_t f);
        int         n;
        int         start;
        int         d;
        logic [7:0] x;
        wr_t        w;
        res_t       r;
        n     = int'({f[1], f[2]});
        start = int'({f[3], f[4]}) % (1 << AW);
        if (n == 0 || n > (1 << AW)) begin
            r.done = 1'b0;
            r.err  = 1'b1;
            r.wcnt = '0;
        end else begin
            x = 8'd0;
            for (int i = 1; i <= 4 + 3 * n; i++) x ^= f[i];
            for (int i = 0; i < n; i++) begin
                d      = int'({f[5 + 3 * i], f[6 + 3 * i], f[7 + 3 * i]}) % (1 << DW);
                w.addr = AW'((start + i) % (1 << AW));
                w.data = DW'(d);
                exp_wr.push_back(w);
            end
            r.done = (f[5 + 3 * n] == x);
            r.err  = !r.done;
            r.wcnt = (AW + 1)'(n);
        end
        exp_res.push_back(r);
    endtask

    // Assemble a frame; illegal counts get only the header.
    task automatic build_frame(input int n, input int adr, input word_q_t words,
                               input bit corrupt, output byte_q_t f);
        logic [15:0] n16;
        logic [15:0] a16;
        logic [23:0] w;
        logic [7:0]  x;
        n16 = 16'(n);
        a16 = 16'(adr);
        f = {};
        f.push_back(8'hA5);
        f.push_back(n16[15:8]);
        f.push_back(n16[7:0]);
        f.push_back(a16[15:8]);
        f.push_back(a16[7:0]);
        if (n >= 1 && n <= (1 << AW)) begin
            foreach (words[i]) begin
                w = words[i];
                f.push_back(w[23:16]);
                f.push_back(w[15:8]);
                f.push_back(w[7:0]);
            end
            x = 8'd0;
            for (int i = 1; i < f.size(); i++) x ^= f[i];
            if (corrupt) x = ~x;
            f.push_back(x);
        end
    endtask

    // One handshake; entered and left at a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit exp_we);
        int waited;
        RX_VALID = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        waited   = 0;
        while (!RX_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!RX_READY) begin
            check("ready_timeout", 32'(RX_READY), 32'd1);
            RX_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        RX_VALID = 1'b0;
        if (exp_we) check("we_latency", 32'(WE), 32'd1);
    endtask

    task automatic send_frame(input byte_q_t f);
        int n;
        bit legal;
        n     = int'({f[1], f[2]});
        legal = (n >= 1) && (n <= (1 << AW));
        for (int i = 0; i < f.size(); i++)
            send_byte(f[i], legal && i >= 5 && i < 5 + 3 * n && ((i - 5) % 3 == 2));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},        32'(A),        32'd0);
        check({tag, "_we"},       32'(WE),       32'd0);
        check({tag, "_di"},       32'(DI),       32'd0);
        check({tag, "_busy"},     32'(BUSY),     32'd0);
        check({tag, "_done"},     32'(DONE),     32'd0);
        check({tag, "_err"},      32'(ERR),      32'd0);
        check({tag, "_wcnt"},     32'(WCNT),     32'd0);
        check({tag, "_rx_ready"}, 32'(RX_READY), 32'd0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("ready_before_first_clk", 32'(RX_READY), 32'd0);
        @(negedge CLK);
        check("ready_after_reset", 32'(RX_READY), 32'd1);
        send_byte(8'h00, 1'b0);
        check("idle_discard_busy", 32'(BUSY), 32'd0);
    endtask

    always @(posedge CLK) rst_last <= RST;

    // Write monitor: every WE pulse must match the next predicted write.
    always @(negedge CLK) begin : wr_mon
        wr_t w;
        if (!RST && WE) begin
            check("ready_low_in_write", 32'(RX_READY), 32'd0);
            if (exp_wr.size() == 0) begin
                check("we_unexpected", 32'(WE), 32'd0);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(A), 32'(w.addr));
                check("wr_data", 32'(DI), 32'(w.data));
            end
        end
        if (!RST && !rst_last && !RX_READY && !WE) bad_ready++;
    end

    // Result monitor: BUSY falling closes a frame.
    always @(negedge CLK) begin : res_mon
        res_t r;
        if (!RST && busy_prev && !BUSY) begin
            if (exp_res.size() == 0) begin
                check("result_unexpected", 32'(exp_res.size()), 32'd1);
            end else begin
                r = exp_res.pop_front();
                check("res_done", 32'(DONE), 32'(r.done));
                check("res_err",  32'(ERR),  32'(r.err));
                check("res_wcnt", 32'(WCNT), 32'(r.wcnt));
            end
        end
        busy_prev <= BUSY;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        byte_q_t f;
        word_q_t wq;
        int      n;
        logic [7:0] junk;

        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;

        // Power-on reset.
        #1 RST = 1'b1;
        #2 check_all_zero("reset");
        release_reset();

        // Single word, literal frame.
        max_gap = 0;
        f = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h10, 8'h03, 8'hFF, 8'hFF, 8'h12};
        model_frame(f);
        send_frame(f);
        check("single_done", 32'(DONE), 32'd1);
        check("single_err",  32'(ERR),  32'd0);
        check("single_wcnt", 32'(WCNT), 32'd1);
        check("single_busy", 32'(BUSY), 32'd0);
        check("single_a",    32'(A),    32'h011);
        check("single_di",   32'(DI),   32'h3FFFF);

        // Address wrap-around.
        wq = {24'd1, 24'd2, 24'd3};
        build_frame(3, 16'hFFE, wq, 1'b0, f);
        model_frame(f);
        send_frame(f);
        check("wrap_done", 32'(DONE), 32'd1);
        check("wrap_a",    32'(A),    32'h001);

        // Bad checksum after two writes.
        wq = {24'($urandom), 24'($urandom)};
        build_frame(2, 16'h0200, wq, 1'b1, f);
        model_frame(f);
        send_frame(f);
        check("badsum_err",  32'(ERR),  32'd1);
        check("badsum_done", 32'(DONE), 32'd0);
        check("badsum_wcnt", 32'(WCNT), 32'd2);

        // Zero count, then a good frame clears ERR.
        f = {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(f);
        send_frame(f);
        check("zero_cnt_err",  32'(ERR),  32'd1);
        check("zero_cnt_busy", 32'(BUSY), 32'd0);
        wq = {24'h123456};
        build_frame(1, 16'hF7FF, wq, 1'b0, f);
        model_frame(f);
        send_frame(f);
        check("recover_done", 32'(DONE), 32'd1);
        check("recover_err",  32'(ERR),  32'd0);

        // Count one beyond the address space.
        wq = {};
        build_frame(4097, 16'h0000, wq, 1'b0, f);
        model_frame(f);
        send_frame(f);
        check("big_cnt_err", 32'(ERR), 32'd1);

        // SYNC-valued bytes inside the data are plain data.
        wq = {24'hA5A5A5, 24'h00A5A5};
        build_frame(2, 16'h00A5, wq, 1'b0, f);
        model_frame(f);
        send_frame(f);
        check("sync_data_done", 32'(DONE), 32'd1);

        // Random frames, junk between frames, varying stall density.
        for (int k = 0; k < 14; k++) begin
            max_gap = k % 4;
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h5A;
                send_byte(junk, 1'b0);
            end
            if (k == 6)       n = 0;
            else if (k == 10) n = $urandom_range(4097, 65535);
            else              n = $urandom_range(1, 6);
            wq = {};
            for (int i = 0; i < n && n <= 6; i++) wq.push_back(24'($urandom));
            build_frame(n, $urandom_range(0, 65535), wq, ($urandom_range(0, 3) == 0), f);
            model_frame(f);
            send_frame(f);
        end

        // Reset in the middle of the second word.
        max_gap = 1;
        wq = {24'h0ABCDE, 24'h111111};
        build_frame(2, 16'h0123, wq, 1'b0, f);
        exp_wr.push_back('{addr: 12'h123, data: 18'h2BCDE});
        for (int i = 0; i < 9; i++) send_byte(f[i], i == 7);
        check("mid_wcnt", 32'(WCNT), 32'd1);
        check("mid_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1 check_all_zero("mid_reset");
        release_reset();
        check("mid_reset_no_pending", 32'(exp_wr.size()), 32'd0);

        // Clean frame after the abort.
        max_gap = 2;
        wq = {24'($urandom), 24'($urandom), 24'($urandom)};
        build_frame(3, 16'h0123, wq, 1'b0, f);
        model_frame(f);
        send_frame(f);

        repeat (5) @(negedge CLK);
        check("writes_drained",  32'(exp_wr.size()),  32'd0);
        check("results_drained", 32'(exp_res.size()), 32'd0);
        check("ready_low_only_in_write", 32'(bad_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
